// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the packet-atomic Avalon-ST arbiter and its skid buffer.
package avalon_arb_pkg;

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} arb_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int RR_MAX     = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // A byte-wide stream still carries a 1-bit empty field so the port never collapses to zero width.
  function automatic int empty_w(input int dwidth);
    return (dwidth > 8) ? $clog2(dwidth / 8) : 1;
  endfunction

  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req, input logic [3:0] last,
                                       input int n);
    rr_pick_t   res;
    logic [3:0] cand;
    res = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      cand = 4'(({1'b0, last} + 5'(k)) % 5'(n));
      if (k <= n && !res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_stream.sv
// Avalon-ST point-to-point stream bundle with ready latency 0.
interface avalon_stream #(parameter int DWIDTH = 64);
  import avalon_arb_pkg::*;

  localparam int EW = empty_w(DWIDTH);

  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;
  logic              error;
  logic [EW-1:0]     empty;
  logic [DWIDTH-1:0] data;

  modport master (output valid, sop, eop, error, empty, data, input ready);
  modport slave  (input valid, sop, eop, error, empty, data, output ready);
endinterface

// File: rtl/avalon_st_skid.sv
// Two-entry registered skid FIFO: the head register drives the sink directly and the
// upstream ready is a flop, so sink ready never reaches the source combinationally.
module avalon_st_skid
  import avalon_arb_pkg::*;
#(
  parameter int DWIDTH = 64
) (
  input logic          clk,
  input logic          reset_n,
  avalon_stream.slave  in_st,
  avalon_stream.master out_st
);

  localparam int EW = empty_w(DWIDTH);
  localparam int BW = 3 + EW + DWIDTH;

  logic [BW-1:0] head_q;
  logic [BW-1:0] tail_q;
  logic [BW-1:0] in_beat;
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          in_ready_q;
  logic          push;
  logic          pop;

  assign in_beat = {in_st.sop, in_st.eop, in_st.error, in_st.empty, in_st.data};
  assign push    = in_st.valid && in_ready_q;
  assign pop     = (count_q != '0) && out_st.ready;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d < 2'(SKID_DEPTH));
      // A full buffer never sees a push, so a pop there only shifts tail into head.
      if (pop && count_q == 2'd2)
        head_q <= tail_q;
      else if (push && (count_q == 2'd0 || pop))
        head_q <= in_beat;
      if (push && count_q == 2'd1 && !pop)
        tail_q <= in_beat;
    end
  end

  assign in_st.ready  = in_ready_q;
  assign out_st.valid = (count_q != '0);
  assign {out_st.sop, out_st.eop, out_st.error, out_st.empty, out_st.data} = head_q;

endmodule

// File: rtl/avalon_st_pkt_arbiter.sv
// Packet-atomic round-robin merge of NUM_IN Avalon-ST sources onto one registered sink.
module avalon_st_pkt_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int NUM_IN = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  avalon_stream.slave               in_st [NUM_IN],
  avalon_stream.master              out_st,
  output logic [$clog2(NUM_IN)-1:0] grant_idx,
  output logic                      busy,
  output logic                      drop_pulse
);

  localparam int GW = $clog2(NUM_IN);
  localparam int EW = empty_w(DWIDTH);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     grant_d;
  logic [GW-1:0]     last_q;
  logic [GW-1:0]     last_d;
  logic [NUM_IN-1:0] in_valid;
  logic [NUM_IN-1:0] in_sop;
  logic [NUM_IN-1:0] in_eop;
  logic [NUM_IN-1:0] in_error;
  logic [NUM_IN-1:0] in_ready;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] stray;
  logic [EW-1:0]     in_empty [NUM_IN];
  logic [DWIDTH-1:0] in_data  [NUM_IN];
  logic              skid_valid;
  rr_pick_t          pick;

  avalon_stream #(.DWIDTH(DWIDTH)) skid_in ();

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    assign in_valid[g]    = in_st[g].valid;
    assign in_sop[g]      = in_st[g].sop;
    assign in_eop[g]      = in_st[g].eop;
    assign in_error[g]    = in_st[g].error;
    assign in_empty[g]    = in_st[g].empty;
    assign in_data[g]     = in_st[g].data;
    assign in_st[g].ready = in_ready[g];
  end

  assign req   = in_valid & in_sop;
  assign stray = in_valid & ~in_sop;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    in_ready   = '0;
    drop_pulse = 1'b0;
    skid_valid = 1'b0;
    pick       = rr_pick(RR_MAX'(req), 4'(last_q), NUM_IN);
    unique case (state_q)
      IDLE: begin
        // Stray discards are held off while reset is asserted so every ready reads 0.
        if (reset_n) begin
          in_ready   = stray;
          drop_pulse = |stray;
        end
        if (pick.found) begin
          grant_d = GW'(pick.idx);
          last_d  = GW'(pick.idx);
          state_d = PKT;
        end
      end
      PKT: begin
        in_ready[grant_q] = skid_in.ready;
        skid_valid        = in_valid[grant_q];
        if (in_valid[grant_q] && skid_in.ready && in_eop[grant_q])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_IN - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign skid_in.valid = skid_valid;
  assign skid_in.sop   = in_sop[grant_q];
  assign skid_in.eop   = in_eop[grant_q];
  assign skid_in.error = in_error[grant_q];
  assign skid_in.empty = in_empty[grant_q];
  assign skid_in.data  = in_data[grant_q];

  avalon_st_skid #(.DWIDTH(DWIDTH)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .in_st   (skid_in),
    .out_st  (out_st)
  );

  assign grant_idx = grant_q;
  assign busy      = (state_q == PKT);

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// Bench for avalon_st_pkt_arbiter: per-source beat queues drive the inputs and a scoreboard
// of expected output beats (with the source that must own the grant) is checked at the sink.
module tb_avalon_st_pkt_arbiter;

  localparam int DW  = 64;
  localparam int NI  = 4;
  localparam int EWT = 3;

  typedef struct packed {
    logic           sop;
    logic           eop;
    logic           error;
    logic [EWT-1:0] empty;
    logic [DW-1:0]  data;
  } beat_t;

  typedef struct packed {
    logic [3:0] src;
    beat_t      b;
  } exp_t;

  typedef struct {
    int         src;
    int         nbeats;
    logic       err;
    logic [2:0] emp;
    int         exp_lat;
    int         exp_grant;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_stream #(.DWIDTH(DW)) in_st [NI] ();
  avalon_stream #(.DWIDTH(DW)) out_st ();

  logic [1:0] grant_idx;
  logic       busy;
  logic       drop_pulse;

  logic  tb_valid [NI];
  logic  tb_ready [NI];
  beat_t tb_beat  [NI];
  logic  tb_out_ready;
  logic  ordy_next;

  for (genvar g = 0; g < NI; g++) begin : g_src
    assign in_st[g].valid = tb_valid[g];
    assign in_st[g].sop   = tb_beat[g].sop;
    assign in_st[g].eop   = tb_beat[g].eop;
    assign in_st[g].error = tb_beat[g].error;
    assign in_st[g].empty = tb_beat[g].empty;
    assign in_st[g].data  = tb_beat[g].data;
    assign tb_ready[g]    = in_st[g].ready;
  end
  assign out_st.ready = tb_out_ready;

  avalon_st_pkt_arbiter #(.DWIDTH(DW), .NUM_IN(NI)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_st      (in_st),
    .out_st     (out_st),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .drop_pulse (drop_pulse)
  );

  beat_t src_q [NI][$];
  exp_t  exp_q [$];
  int    out_cyc [$];
  logic  acc [NI];
  int    acc_cnt [NI];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NI; i++)
      if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive just after the rising edge, sample at the falling edge.
  task automatic tick();
    exp_t        e;
    logic [95:0] got;
    @(posedge clk);
    #1;
    tb_out_ready = ordy_next;
    for (int i = 0; i < NI; i++) begin
      if (acc[i]) begin
        src_q[i].delete(0);
        acc[i] = 1'b0;
      end
      if (src_q[i].size() > 0) begin
        tb_valid[i] = 1'b1;
        tb_beat[i]  = src_q[i][0];
      end else begin
        tb_valid[i] = 1'b0;
        tb_beat[i]  = '0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      acc[i] = tb_valid[i] && tb_ready[i];
      if (acc[i]) acc_cnt[i]++;
    end
    if (out_st.valid && tb_out_ready) begin
      got = 96'({out_st.sop, out_st.eop, out_st.error, out_st.empty, out_st.data});
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h, want no beat", got);
      end else begin
        e = exp_q.pop_front();
        check("out_beat", got, 96'(e.b));
        check("out_grant", 96'(grant_idx), 96'(e.src));
      end
    end
  endtask

  task automatic add_pkt(input int src, input int n, input logic err, input logic [2:0] emp);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.sop   = (k == 0);
      b.eop   = (k == n - 1);
      b.error = (k == n - 1) ? err : 1'b0;
      b.empty = (k == n - 1) ? emp : 3'($urandom_range(0, 7));
      b.data  = {$urandom(), $urandom()};
      src_q[src].push_back(b);
      exp_q.push_back({4'(src), b});
    end
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() > 0 || pending()) && n < bound) begin
      tick();
      n++;
    end
    check({name, "_drain_in_time"}, 96'(n < bound), 96'(1));
    repeat (2) tick();
  endtask

  task automatic clear_bench();
    exp_q.delete();
    out_cyc.delete();
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      acc[i]      = 1'b0;
      tb_valid[i] = 1'b0;
      tb_beat[i]  = '0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_bench();
    ordy_next    = 1'b1;
    tb_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_out_valid"}, 96'(out_st.valid), 96'(0));
    check({name, "_out_flags"}, 96'({out_st.sop, out_st.eop, out_st.error}), 96'(0));
    check({name, "_out_data"}, 96'({out_st.empty, out_st.data}), 96'(0));
    check({name, "_busy_drop"}, 96'({busy, drop_pulse}), 96'(0));
    check({name, "_grant"}, 96'(grant_idx), 96'(0));
    check({name, "_readies"}, 96'({tb_ready[0], tb_ready[1], tb_ready[2], tb_ready[3]}), 96'(0));
  endtask

  vec_t vecs [5];
  int   exp_a [6];

  initial begin
    int c0;
    int base;

    vecs[0] = '{src: 1, nbeats: 2, err: 1'b0, emp: 3'd5, exp_lat: 2, exp_grant: 1};
    vecs[1] = '{src: 3, nbeats: 3, err: 1'b1, emp: 3'd3, exp_lat: 2, exp_grant: 3};
    vecs[2] = '{src: 0, nbeats: 1, err: 1'b0, emp: 3'd0, exp_lat: 2, exp_grant: 0};
    vecs[3] = '{src: 2, nbeats: 4, err: 1'b0, emp: 3'd7, exp_lat: 2, exp_grant: 2};
    vecs[4] = '{src: 3, nbeats: 1, err: 1'b1, emp: 3'd6, exp_lat: 2, exp_grant: 3};
    exp_a   = '{2, 3, 4, 6, 7, 8};

    for (int i = 0; i < NI; i++) acc_cnt[i] = 0;
    clear_bench();
    ordy_next    = 1'b1;
    tb_out_ready = 1'b1;

    // Reset state, with a stray beat offered so the gated readies are exercised.
    reset_n     = 1'b0;
    tb_valid[1] = 1'b1;
    tb_beat[1]  = '{sop: 1'b0, eop: 1'b0, error: 1'b0, empty: 3'd0, data: 64'h1234};
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    clear_bench();
    reset_n = 1'b1;

    // Two contending 3-beat packets: source 0 first, then source 2 after one bubble.
    add_pkt(0, 3, 1'b0, 3'd0);
    add_pkt(2, 3, 1'b0, 3'd0);
    tick();
    c0 = cyc;
    drain("two_src", 40);
    check("two_src_count", 96'(out_cyc.size()), 96'(6));
    if (out_cyc.size() == 6)
      for (int k = 0; k < 6; k++) check("two_src_cycle", 96'(out_cyc[k] - c0), 96'(exp_a[k]));

    // Table: lone packets with error/empty patterns, latency and held grant.
    for (int v = 0; v < 5; v++) begin
      out_cyc.delete();
      add_pkt(vecs[v].src, vecs[v].nbeats, vecs[v].err, vecs[v].emp);
      tick();
      c0 = cyc;
      drain("vec", 40);
      check("vec_count", 96'(out_cyc.size()), 96'(vecs[v].nbeats));
      if (out_cyc.size() == vecs[v].nbeats) begin
        check("vec_latency", 96'(out_cyc[0] - c0), 96'(vecs[v].exp_lat));
        check("vec_last_cycle", 96'(out_cyc[vecs[v].nbeats - 1] - c0),
              96'(vecs[v].exp_lat + vecs[v].nbeats - 1));
      end
      check("vec_grant_held", 96'(grant_idx), 96'(vecs[v].exp_grant));
    end

    // All sources offer single-beat packets continuously: strict rotation, one beat per 2 cycles.
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < NI; s++) add_pkt(s, 1, 1'b0, 3'(s));
    out_cyc.delete();
    tick();
    drain("rr", 100);
    check("rr_count", 96'(out_cyc.size()), 96'(12));
    if (out_cyc.size() == 12)
      for (int k = 1; k < 12; k++) check("rr_spacing", 96'(out_cyc[k] - out_cyc[k-1]), 96'(2));

    // Sink stalls for 5 cycles from the second output beat of a 4-beat packet.
    base = acc_cnt[1];
    add_pkt(1, 4, 1'b0, 3'd2);
    tick();
    tick();
    tick();
    ordy_next = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      tick();
      check("stall_out_valid", 96'(out_st.valid), 96'(1));
      if (k >= 4) check("stall_in_ready", 96'(tb_ready[1]), 96'(0));
    end
    check("stall_absorbed", 96'(acc_cnt[1] - base), 96'(3));
    ordy_next = 1'b1;
    drain("stall", 40);

    // Stray non-SOP beats in IDLE are discarded with a pulse each cycle.
    for (int k = 0; k < 2; k++)
      src_q[3].push_back('{sop: 1'b0, eop: 1'b0, error: 1'b0, empty: 3'd1, data: {$urandom(), $urandom()}});
    tick();
    check("stray1_drop", 96'({drop_pulse, tb_ready[3]}), 96'(2'b11));
    check("stray1_idle", 96'({out_st.valid, busy}), 96'(0));
    tick();
    check("stray2_drop", 96'(drop_pulse), 96'(1));
    tick();
    check("stray_after_drop", 96'(drop_pulse), 96'(0));
    check("stray_after_valid", 96'(out_st.valid), 96'(0));

    // Asynchronous reset in the middle of a 6-beat packet from source 2.
    add_pkt(2, 6, 1'b0, 3'd4);
    repeat (5) tick();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("midpkt_reset");
    clear_bench();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    add_pkt(0, 2, 1'b0, 3'd1);
    add_pkt(2, 2, 1'b0, 3'd2);
    out_cyc.delete();
    tick();
    c0 = cyc;
    drain("post_reset", 40);
    check("post_reset_count", 96'(out_cyc.size()), 96'(4));
    if (out_cyc.size() > 0) check("post_reset_latency", 96'(out_cyc[0] - c0), 96'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/avalon_st_pkt_arbiter.md
# avalon_st_pkt_arbiter

Packet-atomic round-robin arbiter that merges NUM_IN Avalon-ST `avalon_stream` sources onto one `avalon_stream` sink. A grant locks to one source from SOP until its EOP beat is accepted, so packets are never interleaved. The output is fully registered through a 2-entry skid buffer, so out-side ready never reaches any input ready combinationally. The block sits between the per-channel packet generators and the shared downstream packet engine.

## Interface
- DWIDTH, 64, data width of every stream; `empty` width is $clog2(DWIDTH/8)
- NUM_IN, 4, number of source streams, 2..16
- clk  input  1  sole clock, all logic rising-edge
- reset_n  input  1  asynchronous, active-low reset
- in_st[NUM_IN]  avalon_stream.slave  DWIDTH  source streams; block drives ready
- out_st  avalon_stream.master  DWIDTH  merged stream; block drives valid/sop/eop/error/data/empty
- grant_idx  output  $clog2(NUM_IN)  index of the source currently owning the output
- busy  output  1  high while in PKT state
- drop_pulse  output  1  one-cycle pulse per discarded stray (non-SOP) beat in IDLE

## Operation
- Ready latency 0: a beat transfers on a cycle where valid && ready are both high.
- States (shared enum): IDLE, PKT.
- IDLE: a request is in_st[i].valid && in_st[i].sop. Round-robin search starts at last_grant+1 mod NUM_IN. On a hit, register grant_idx = winner and last_grant = winner, then go to PKT. No input beat is accepted in the arbitration cycle.
- IDLE stray beats: if in_st[i].valid && !sop, drive in_st[i].ready=1 and discard the beat. Pulse drop_pulse once per cycle in which at least one beat is discarded. An input that asserts valid with sop in the same cycle is never discarded.
- PKT: in_st[grant_idx].ready = skid_in_ready. Every other input's ready = 0.
- Accepted beats are written into the skid buffer with sop/eop/error/data/empty unchanged. `empty` is passed through verbatim, including on non-EOP beats.
- On acceptance of a beat with eop=1, go to IDLE the next cycle. A single-beat packet (sop && eop) lasts exactly one PKT cycle.
- A SOP seen mid-packet on the granted source is forwarded unchanged; the block does not repair protocol errors.
- out_st.valid = skid buffer not empty. Entries pop when out_st.ready is high.

## Timing
- Reset: the asynchronous assert clears state to IDLE, the skid buffer to empty, last_grant to NUM_IN-1 (so source 0 wins first), and grant_idx to 0. busy, drop_pulse, out_st.valid/sop/eop/error, all in_st ready, out_st.data and out_st.empty are all 0.
- Reset mid-packet truncates the packet: no EOP is emitted, and buffered beats are lost.
- Latency from SOP valid at cycle 0 (IDLE, no stall): grant at cycle 1 edge; SOP accepted in cycle 1; out_st.valid with sop at cycle 2.
- Steady state with out_st.ready=1: one beat per cycle, then a 1-cycle arbitration bubble between packets. EOP accepted in cycle k means the next SOP is accepted no earlier than cycle k+2.
- Skid buffer: skid_in_ready = (count < 2), registered. With out_st.ready low, at most 2 beats are absorbed after the stall begins. Simultaneous push and pop at count 2 is not allowed because skid_in_ready is already low.
- grant_idx holds its value through IDLE until the next grant.

## Structure
- Package avalon_arb_pkg holds:
  - arb_state_t enum {IDLE, PKT};
  - function rr_pick(req, last) returning the winner index and a found flag;
  - localparam SKID_DEPTH = 2.
- Sub-module avalon_st_skid: a 2-entry registered FIFO of {sop, eop, error, empty, data} with avalon_stream slave/master modports. It is reusable elsewhere in the codebase.
- The top level holds the FSM, the round-robin pointer, and the ready/valid muxing.

## Test plan
- Sources 0 and 2 each present a 3-beat packet at cycle 0, out_st.ready=1 -> source 0 beats on out at cycles 2-4, source 2 beats at cycles 6-8, grant_idx 0 then 2.
- All 4 sources continuously offer single-beat packets -> output order 0,1,2,3,0,… with one beat every 2 cycles; no input starves.
- Source 1 offers a 4-beat packet, out_st.ready low for 5 cycles from the second beat -> exactly 2 beats are buffered, in_st[1].ready drops, and no beat is lost or duplicated after ready returns.
- In IDLE, source 3 drives valid without sop for 2 cycles -> both beats are discarded, drop_pulse is high for 2 cycles, out_st.valid stays 0.
- Packet with error=1 and empty=3 on EOP -> out EOP beat carries error=1, empty=3, and data is bit-exact.
- reset_n asserted in the middle of a 6-beat packet -> all outputs are 0 immediately (asynchronous); after release, source 0 wins the first arbitration.
